// File: rtl/age_issue_queue_if.sv
// age_issue_queue_if: dispatch, wakeup, issue and squash signals of the age-ordered issue queue
interface age_issue_queue_if #(
    parameter int DEPTH     = 6,
    parameter int INPORTS   = 2,
    parameter int OUTS      = 2,
    parameter int IDX_W     = 7,
    parameter int PREG_W    = 7,
    parameter int WK        = 4,
    parameter int PAYLOAD_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INPORTS-1:0]                    i_enq_vld;
    logic                                  o_enq_rdy;
    logic [INPORTS-1:0][IDX_W:0]           i_enq_age;
    logic [INPORTS-1:0][1:0][PREG_W-1:0]   i_enq_psrc;
    logic [INPORTS-1:0][1:0]               i_enq_src_rdy;
    logic [INPORTS-1:0][PAYLOAD_W-1:0]     i_enq_payload;
    logic [WK-1:0]                         i_wk_vld;
    logic [WK-1:0][PREG_W-1:0]             i_wk_preg;
    logic [OUTS-1:0]                       o_iss_vld;
    logic [OUTS-1:0]                       i_iss_rdy;
    logic [OUTS-1:0][IDX_W:0]              o_iss_age;
    logic [OUTS-1:0][PAYLOAD_W-1:0]        o_iss_payload;
    logic                                  i_squash_vld;
    logic [IDX_W:0]                        i_squash_age;
    logic [CNT_W-1:0]                      o_count;

    modport master (
        output i_enq_vld, i_enq_age, i_enq_psrc, i_enq_src_rdy, i_enq_payload,
        output i_wk_vld, i_wk_preg, i_iss_rdy, i_squash_vld, i_squash_age,
        input  o_enq_rdy, o_iss_vld, o_iss_age, o_iss_payload, o_count
    );

    modport slave (
        input  i_enq_vld, i_enq_age, i_enq_psrc, i_enq_src_rdy, i_enq_payload,
        input  i_wk_vld, i_wk_preg, i_iss_rdy, i_squash_vld, i_squash_age,
        output o_enq_rdy, o_iss_vld, o_iss_age, o_iss_payload, o_count
    );
endinterface

// File: rtl/age_issue_queue.sv
// age_issue_queue: out-of-order issue queue selecting the oldest ready micro-ops with ROB wrap-aware ages
module age_issue_queue #(
    parameter int DEPTH     = 6,
    parameter int INPORTS   = 2,
    parameter int OUTS      = 2,
    parameter int IDX_W     = 7,
    parameter int PREG_W    = 7,
    parameter int WK        = 4,
    parameter int PAYLOAD_W = 64
) (
    input logic              clk,
    input logic              rst,
    age_issue_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = IDX_W + 1;

    logic [DEPTH-1:0]              vld, vld_d, rdy, fire, alloc_taken;
    logic [AGE_W-1:0]              age [DEPTH];
    logic [AGE_W-1:0]              age_d [DEPTH];
    logic [1:0][PREG_W-1:0]        psrc [DEPTH];
    logic [1:0][PREG_W-1:0]        psrc_d [DEPTH];
    logic [1:0]                    srdy [DEPTH];
    logic [1:0]                    srdy_d [DEPTH];
    logic [PAYLOAD_W-1:0]          payload [DEPTH];
    logic [PAYLOAD_W-1:0]          payload_d [DEPTH];
    logic [CNT_W-1:0]              rank [DEPTH];
    logic [CNT_W-1:0]              count, count_d;
    logic                          enq_rdy, port_done;

    // a is older than b; the MSB is the ROB wrap flag, so differing flags invert the index order
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        return (a[IDX_W] == b[IDX_W]) ? (a[IDX_W-1:0] < b[IDX_W-1:0]) : (a[IDX_W-1:0] > b[IDX_W-1:0]);
    endfunction

    function automatic logic woken(input logic [WK-1:0] v, input logic [WK-1:0][PREG_W-1:0] p,
                                   input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WK; w++)
            hit = hit | (v[w] && p[w] == tag);
        return hit;
    endfunction

    // enqueue only with room for a full dispatch group; no slot reuse from same-cycle issue
    assign enq_rdy       = (count <= CNT_W'(DEPTH - INPORTS)) && !bus.i_squash_vld;
    assign bus.o_enq_rdy = enq_rdy;
    assign bus.o_count   = count;

    // an entry can issue once valid with both sources ready
    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            rdy[e] = vld[e] & srdy[e][0] & srdy[e][1];
    end

    // rank of each ready entry = number of ready entries older than it (ages are unique)
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            rank[e] = '0;
            for (int j = 0; j < DEPTH; j++)
                rank[e] = rank[e] + CNT_W'(rdy[j] && j != e && older(age[j], age[e]));
        end
    end

    // port k presents the ready entry of rank k; squash suppresses issue and therefore fires
    always_comb begin
        bus.o_iss_vld     = '0;
        bus.o_iss_age     = '0;
        bus.o_iss_payload = '0;
        fire              = '0;
        for (int k = 0; k < OUTS; k++)
            for (int e = 0; e < DEPTH; e++)
                if (rdy[e] && rank[e] == CNT_W'(k)) begin
                    bus.o_iss_vld[k]     = !bus.i_squash_vld;
                    bus.o_iss_age[k]     = age[e];
                    bus.o_iss_payload[k] = payload[e];
                    fire[e]              = !bus.i_squash_vld && bus.i_iss_rdy[k];
                end
    end

    // next entry state: squash kills younger, fire frees, wakeup sets srdy, enqueue fills lowest free slots
    always_comb begin
        vld_d       = vld;
        age_d       = age;
        psrc_d      = psrc;
        srdy_d      = srdy;
        payload_d   = payload;
        alloc_taken = '0;
        port_done   = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if ((bus.i_squash_vld && older(bus.i_squash_age, age[e])) || fire[e])
                vld_d[e] = 1'b0;
            for (int s = 0; s < 2; s++)
                srdy_d[e][s] = srdy[e][s] | woken(bus.i_wk_vld, bus.i_wk_preg, psrc[e][s]);
        end
        for (int p = 0; p < INPORTS; p++) begin
            port_done = 1'b0;
            for (int e = 0; e < DEPTH; e++)
                if (bus.i_enq_vld[p] && enq_rdy && !port_done && !vld[e] && !alloc_taken[e]) begin
                    port_done      = 1'b1;
                    alloc_taken[e] = 1'b1;
                    vld_d[e]       = 1'b1;
                    age_d[e]       = bus.i_enq_age[p];
                    psrc_d[e]      = bus.i_enq_psrc[p];
                    payload_d[e]   = bus.i_enq_payload[p];
                    for (int s = 0; s < 2; s++)
                        srdy_d[e][s] = bus.i_enq_src_rdy[p][s] |
                                       woken(bus.i_wk_vld, bus.i_wk_preg, bus.i_enq_psrc[p][s]);
                end
        end
    end

    // count tracks the population of the next valid vector
    always_comb begin
        count_d = '0;
        for (int e = 0; e < DEPTH; e++)
            count_d = count_d + CNT_W'(vld_d[e]);
    end

    // state register; entry contents need no reset because vld gates them
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= vld_d;
            count <= count_d;
        end
        age     <= age_d;
        psrc    <= psrc_d;
        srdy    <= srdy_d;
        payload <= payload_d;
    end
endmodule

// File: tb/tb_age_issue_queue.sv
// tb_age_issue_queue: scoreboard bench with a list-based reference model of the age issue queue
module tb_age_issue_queue;
    localparam int DEPTH = 6, INPORTS = 2, OUTS = 2;

    typedef struct {
        logic [7:0]      age;
        logic [1:0][6:0] psrc;
        logic [1:0]      srdy;
        logic [63:0]     payload;
    } ent_t;

    typedef struct {
        int               cnt;
        logic             erdy;
        logic [1:0]       ivld;
        logic [1:0][7:0]  iage;
        logic [1:0][63:0] ipay;
    } st_t;

    typedef struct {
        int          port;
        logic [7:0]  age;
        logic [63:0] payload;
    } fire_t;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0, mismatched = 0;
    bit   checking = 1'b0;
    ent_t mq[$];
    st_t  stq[$];
    fire_t fq[$];
    st_t  ms;
    fire_t mf;
    logic [7:0] robptr;

    age_issue_queue_if bus();
    age_issue_queue dut (.clk(clk), .rst(rst), .bus(bus));

    // free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a older than b when b lies 1..127 steps after a on the 256-entry age circle
    function automatic bit m_older(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = b - a;
        return d >= 8'd1 && d <= 8'd127;
    endfunction

    function automatic bit m_woken(input logic [6:0] t);
        for (int w = 0; w < 4; w++)
            if (bus.i_wk_vld[w] && bus.i_wk_preg[w] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_in();
        rst               = 1'b0;
        bus.i_enq_vld     = '0;
        bus.i_enq_age     = '0;
        bus.i_enq_psrc    = '0;
        bus.i_enq_src_rdy = '0;
        bus.i_enq_payload = '0;
        bus.i_wk_vld      = '0;
        bus.i_wk_preg     = '0;
        bus.i_iss_rdy     = '0;
        bus.i_squash_vld  = 1'b0;
        bus.i_squash_age  = '0;
    endtask

    task automatic enq(input int p, input logic [7:0] a, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [1:0] r);
        bus.i_enq_vld[p]       = 1'b1;
        bus.i_enq_age[p]       = a;
        bus.i_enq_psrc[p][0]   = s0;
        bus.i_enq_psrc[p][1]   = s1;
        bus.i_enq_src_rdy[p]   = r;
        bus.i_enq_payload[p]   = {$urandom, $urandom};
    endtask

    task automatic wake(input int w, input logic [6:0] t);
        bus.i_wk_vld[w]  = 1'b1;
        bus.i_wk_preg[w] = t;
    endtask

    // predict this cycle's outputs from the model, queue them, then advance the model at the edge
    task automatic step();
        int rl[$];
        int ord[$];
        logic [7:0] fa[$];
        ent_t nq[$];
        ent_t ne;
        st_t s;
        fire_t f;
        bit gone;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].srdy == 2'b11) rl.push_back(i);
        while (rl.size() > 0) begin
            int b = 0;
            for (int j = 1; j < rl.size(); j++)
                if (m_older(mq[rl[j]].age, mq[rl[b]].age)) b = j;
            ord.push_back(rl[b]);
            rl.delete(b);
        end
        s.cnt  = mq.size();
        s.erdy = (DEPTH - mq.size() >= INPORTS) && !bus.i_squash_vld;
        s.ivld = '0;
        s.iage = '0;
        s.ipay = '0;
        for (int k = 0; k < OUTS; k++)
            if (k < ord.size() && !bus.i_squash_vld) begin
                s.ivld[k] = 1'b1;
                s.iage[k] = mq[ord[k]].age;
                s.ipay[k] = mq[ord[k]].payload;
                if (bus.i_iss_rdy[k]) begin
                    f.port = k;
                    f.age = s.iage[k];
                    f.payload = s.ipay[k];
                    fq.push_back(f);
                    fa.push_back(f.age);
                end
            end
        stq.push_back(s);
        @(posedge clk);
        if (rst) mq.delete();
        else begin
            foreach (mq[i]) begin
                gone = bus.i_squash_vld && m_older(bus.i_squash_age, mq[i].age);
                foreach (fa[j]) if (fa[j] == mq[i].age) gone = 1'b1;
                if (!gone) begin
                    ne = mq[i];
                    for (int x = 0; x < 2; x++) if (m_woken(ne.psrc[x])) ne.srdy[x] = 1'b1;
                    nq.push_back(ne);
                end
            end
            if (s.erdy)
                for (int p = 0; p < INPORTS; p++)
                    if (bus.i_enq_vld[p]) begin
                        ne.age = bus.i_enq_age[p];
                        ne.psrc = bus.i_enq_psrc[p];
                        ne.payload = bus.i_enq_payload[p];
                        for (int x = 0; x < 2; x++)
                            ne.srdy[x] = bus.i_enq_src_rdy[p][x] | m_woken(ne.psrc[x]);
                        nq.push_back(ne);
                    end
            mq = nq;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            clear_in();
            bus.i_iss_rdy = 2'b11;
            for (int w = 0; w < 4; w++) wake(w, 7'(4 * (i % 4) + w));
            step();
        end
        clear_in();
    endtask

    function automatic bit window_ok();
        logic [7:0] o;
        if (mq.size() == 0) return 1'b1;
        o = mq[0].age;
        foreach (mq[i]) if (m_older(mq[i].age, o)) o = mq[i].age;
        return 8'(robptr - o) < 8'd100;
    endfunction

    // monitor: per-cycle status scoreboard and per-fire issue scoreboard
    always @(negedge clk) if (checking) begin
        if (stq.size() > 0) begin
            ms = stq.pop_front();
            chk("count", 64'(bus.o_count), 64'(ms.cnt));
            chk("enq_rdy", 64'(bus.o_enq_rdy), 64'(ms.erdy));
            chk("iss_vld", 64'(bus.o_iss_vld), 64'(ms.ivld));
            for (int k = 0; k < OUTS; k++)
                if (ms.ivld[k]) begin
                    chk("iss_age", 64'(bus.o_iss_age[k]), 64'(ms.iage[k]));
                    chk("iss_payload", bus.o_iss_payload[k], ms.ipay[k]);
                end
        end
        for (int k = 0; k < OUTS; k++)
            if (bus.o_iss_vld[k] && bus.i_iss_rdy[k]) begin
                if (fq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_fire: port %0d age %0h, expected no fire", k, bus.o_iss_age[k]);
                end else begin
                    mf = fq.pop_front();
                    chk("fire_port", 64'(k), 64'(mf.port));
                    chk("fire_age", 64'(bus.o_iss_age[k]), 64'(mf.age));
                    chk("fire_payload", bus.o_iss_payload[k], mf.payload);
                end
            end
    end

    // watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // directed scenarios followed by randomized traffic
    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_in();
        #1;
        chk("reset_count", 64'(bus.o_count), 64'd0);
        chk("reset_enq_rdy", 64'(bus.o_enq_rdy), 64'd1);
        chk("reset_iss_vld", 64'(bus.o_iss_vld), 64'd0);
        checking = 1'b1;
        // oldest-first select
        enq(0, 8'd134, 7'd0, 7'd0, 2'b11); enq(1, 8'd133, 7'd0, 7'd0, 2'b11); step(); clear_in();
        enq(0, 8'd132, 7'd0, 7'd0, 2'b11); enq(1, 8'd131, 7'd0, 7'd0, 2'b11); step(); clear_in();
        enq(0, 8'd130, 7'd0, 7'd0, 2'b11); step(); clear_in();
        bus.i_iss_rdy = 2'b11; #1;
        chk("t1_age0_a", 64'(bus.o_iss_age[0]), 64'd130);
        chk("t1_age1_a", 64'(bus.o_iss_age[1]), 64'd131);
        step(); #1;
        chk("t1_age0_b", 64'(bus.o_iss_age[0]), 64'd132);
        chk("t1_age1_b", 64'(bus.o_iss_age[1]), 64'd133);
        step(); #1;
        chk("t1_vld_c", 64'(bus.o_iss_vld), 64'd1);
        chk("t1_age0_c", 64'(bus.o_iss_age[0]), 64'd134);
        step(); clear_in(); #1;
        chk("t1_count_end", 64'(bus.o_count), 64'd0);
        // wrap-around order
        enq(0, 8'd130, 7'd0, 7'd0, 2'b11); enq(1, 8'd127, 7'd0, 7'd0, 2'b11); step(); clear_in();
        bus.i_iss_rdy = 2'b11; #1;
        chk("t2_port0", 64'(bus.o_iss_age[0]), 64'd127);
        chk("t2_port1", 64'(bus.o_iss_age[1]), 64'd130);
        step(); clear_in();
        // wakeup latency and enqueue bypass
        enq(0, 8'd10, 7'd5, 7'd0, 2'b10); step(); clear_in();
        bus.i_iss_rdy = 2'b01; #1;
        chk("t3_not_ready", 64'(bus.o_iss_vld), 64'd0);
        step(); clear_in();
        wake(0, 7'd5); #1;
        chk("t3_wake_cycle", 64'(bus.o_iss_vld), 64'd0);
        step(); clear_in();
        bus.i_iss_rdy = 2'b01; #1;
        chk("t3_after_wake", 64'(bus.o_iss_vld[0]), 64'd1);
        step(); clear_in();
        enq(0, 8'd11, 7'd6, 7'd0, 2'b10); wake(1, 7'd6); step(); clear_in();
        bus.i_iss_rdy = 2'b01; #1;
        chk("t3_bypass", 64'(bus.o_iss_vld[0]), 64'd1);
        step(); clear_in();
        // full queue and backpressure
        for (int i = 0; i < 3; i++) begin
            enq(0, 8'(40 + 2 * i), 7'(20 + 2 * i), 7'd0, 2'b10);
            enq(1, 8'(41 + 2 * i), 7'(21 + 2 * i), 7'd0, 2'b10);
            step(); clear_in();
        end
        #1;
        chk("t4_full_rdy", 64'(bus.o_enq_rdy), 64'd0);
        chk("t4_full_count", 64'(bus.o_count), 64'd6);
        enq(0, 8'd46, 7'd0, 7'd0, 2'b11); enq(1, 8'd47, 7'd0, 7'd0, 2'b11); step(); clear_in(); #1;
        chk("t4_ignored", 64'(bus.o_count), 64'd6);
        for (int w = 0; w < 4; w++) wake(w, 7'(20 + w));
        step(); clear_in();
        wake(0, 7'd24); wake(1, 7'd25); step(); clear_in();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_hold0", 64'(bus.o_iss_age[0]), 64'd40);
            chk("t4_hold1", 64'(bus.o_iss_age[1]), 64'd41);
            step(); clear_in();
        end
        drain();
        // squash
        for (int i = 0; i < 3; i++) begin
            enq(0, 8'(129 + 2 * i), 7'd0, 7'd0, 2'b11);
            enq(1, 8'(130 + 2 * i), 7'd0, 7'd0, 2'b11);
            step(); clear_in();
        end
        bus.i_squash_vld = 1'b1; bus.i_squash_age = 8'd131; bus.i_iss_rdy = 2'b11; #1;
        chk("t5_no_issue", 64'(bus.o_iss_vld), 64'd0);
        chk("t5_no_enq", 64'(bus.o_enq_rdy), 64'd0);
        step(); clear_in(); #1;
        chk("t5_count", 64'(bus.o_count), 64'd3);
        chk("t5_oldest", 64'(bus.o_iss_age[0]), 64'd129);
        drain();
        // reset mid-run
        enq(0, 8'd60, 7'd30, 7'd0, 2'b10); enq(1, 8'd61, 7'd30, 7'd0, 2'b10); step(); clear_in();
        enq(0, 8'd62, 7'd30, 7'd0, 2'b10); enq(1, 8'd63, 7'd0, 7'd0, 2'b11); step(); clear_in();
        rst = 1'b1; step(); clear_in(); #1;
        chk("t6_count", 64'(bus.o_count), 64'd0);
        chk("t6_iss_vld", 64'(bus.o_iss_vld), 64'd0);
        chk("t6_enq_rdy", 64'(bus.o_enq_rdy), 64'd1);
        // randomized traffic
        robptr = 8'd200;
        for (int c = 0; c < 2000; c++) begin
            clear_in();
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else if (mq.size() > 0 && $urandom_range(0, 15) == 0) begin
                bus.i_squash_vld = 1'b1;
                bus.i_squash_age = mq[$urandom_range(0, mq.size() - 1)].age;
                robptr = bus.i_squash_age + 8'd1;
            end else
                for (int p = 0; p < INPORTS; p++)
                    if ($urandom_range(0, 2) != 0 && window_ok()) begin
                        enq(p, robptr, 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                            2'($urandom_range(0, 3)));
                        robptr = robptr + 8'd1;
                    end
            for (int w = 0; w < 4; w++)
                if ($urandom_range(0, 1) == 1) wake(w, 7'($urandom_range(0, 15)));
            bus.i_iss_rdy = 2'($urandom_range(0, 3));
            step();
        end
        drain();
        @(negedge clk);
        #1;
        chk("fire_queue_drained", 64'(fq.size()), 64'd0);
        chk("status_queue_drained", 64'(stq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
